// File: rtl/ysyx_22050078_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050078_ifu_fetch
// Brief    : Instruction fetch unit. Owns the fetch PC, keeps one imem request
//            in flight and hands each instruction with its PC to IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050078_ifu_fetch #(
  parameter int          CPU_WIDTH = 64,
  parameter int          INS_WIDTH = 32,
  parameter logic [63:0] RESET_PC  = 64'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc,
  output logic                 o_imem_req,
  output logic [CPU_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [INS_WIDTH-1:0] i_imem_rdata,
  output logic                 o_ifu_valid,
  output logic [INS_WIDTH-1:0] o_ifu_ins,
  output logic [CPU_WIDTH-1:0] o_ifu_pc
);

  localparam logic [INS_WIDTH-1:0] c_nop        = INS_WIDTH'(32'h0000_0013);
  localparam logic [CPU_WIDTH-1:0] c_align_mask = ~(CPU_WIDTH'(3));

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CPU_WIDTH-1:0]   r_pc;
  logic [CPU_WIDTH-1:0]   r_req_pc;
  logic                   r_drop;
  logic                   r_ifu_valid;
  logic [INS_WIDTH-1:0]   r_ifu_ins;
  logic [CPU_WIDTH-1:0]   r_ifu_pc;
  logic [CPU_WIDTH-1:0]   w_redirect_pc;

  assign w_redirect_pc = i_redirect_pc & c_align_mask;

  // Request is masked during reset so a stale state never leaks onto the bus.
  assign o_imem_req  = !i_rst && (r_state == S_REQ);
  assign o_imem_addr = r_pc;

  assign o_ifu_valid = r_ifu_valid;
  assign o_ifu_ins   = r_ifu_ins;
  assign o_ifu_pc    = r_ifu_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC[CPU_WIDTH-1:0];
      r_req_pc    <= '0;
      r_drop      <= 1'b0;
      r_ifu_valid <= 1'b0;
      r_ifu_ins   <= c_nop;
      r_ifu_pc    <= '0;
    end else if (i_redirect) begin
      // Redirect wins over stall and normal flow; anything on the old path dies.
      r_pc        <= w_redirect_pc;
      r_ifu_valid <= 1'b0;
      r_ifu_ins   <= c_nop;
      r_ifu_pc    <= '0;
      case (r_state)
        S_REQ: begin
          if (i_imem_gnt) begin
            r_req_pc <= r_pc;
            r_drop   <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end else begin
            r_drop  <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_imem_gnt) begin
            r_req_pc <= r_pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_ifu_valid <= 1'b1;
              r_ifu_ins   <= i_imem_rdata;
              r_ifu_pc    <= r_req_pc;
              r_pc        <= r_req_pc + CPU_WIDTH'(4);
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            r_ifu_valid <= 1'b0;
            r_ifu_ins   <= c_nop;
            r_ifu_pc    <= '0;
            r_state     <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050078_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050078_ifu_fetch
// Brief    : Scripted imem model with a scoreboard of expected {pc, ins}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050078_ifu_fetch;

  localparam int CPU_WIDTH = 64;
  localparam int INS_WIDTH = 32;
  localparam logic [63:0] c_nop = 64'h13;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall;
  logic                 redirect;
  logic [CPU_WIDTH-1:0] redirect_pc;
  logic                 imem_req;
  logic [CPU_WIDTH-1:0] imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [INS_WIDTH-1:0] imem_rdata;
  logic                 ifu_valid;
  logic [INS_WIDTH-1:0] ifu_ins;
  logic [CPU_WIDTH-1:0] ifu_pc;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [CPU_WIDTH-1:0] pc;
    logic [INS_WIDTH-1:0] ins;
  } sb_item_t;
  sb_item_t sb_q[$];

  always #5 clk = ~clk;

  ysyx_22050078_ifu_fetch #(
    .CPU_WIDTH(CPU_WIDTH),
    .INS_WIDTH(INS_WIDTH),
    .RESET_PC (64'h8000_0000)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (imem_gnt),
    .i_imem_rvalid(imem_rvalid),
    .i_imem_rdata (imem_rdata),
    .o_ifu_valid  (ifu_valid),
    .o_ifu_ins    (ifu_ins),
    .o_ifu_pc     (ifu_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each rising edge of o_ifu_valid must match the oldest expected instruction.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst && ifu_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'(ifu_pc), 64'h0);
      end else begin
        sb_item_t e;
        e = sb_q.pop_front();
        check("sb_ins", 64'(ifu_ins), 64'(e.ins));
        check("sb_pc", ifu_pc, e.pc);
      end
    end
    prev_valid <= ifu_valid;
  end

  // Grants at the current address, answers after lat cycles, leaves DUT in HOLD.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data, input int lat);
    sb_item_t e;
    check("fetch_req", 64'(imem_req), 64'h1);
    check("fetch_addr", imem_addr, addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wait_req", 64'(imem_req), 64'h0);
    for (int i = 1; i < lat; i++) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    e.pc  = addr;
    e.ins = data;
    sb_q.push_back(e);
    tick();
    imem_rvalid = 1'b0;
    check("hold_valid", 64'(ifu_valid), 64'h1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_req", 64'(imem_req), 64'h0);
    check("rst_valid", 64'(ifu_valid), 64'h0);
    check("rst_ins", 64'(ifu_ins), c_nop);
    check("rst_pc", ifu_pc, 64'h0);
    rst = 1'b0;
    #1;
    check("first_req", 64'(imem_req), 64'h1);

    // Best case fetch then consume
    do_fetch(64'h8000_0000, 32'h0000_0093, 1);
    check("t1_pc", ifu_pc, 64'h8000_0000);
    tick();
    check("t1_consumed", 64'(ifu_valid), 64'h0);
    check("t1_next_req", 64'(imem_req), 64'h1);
    check("t1_next_addr", imem_addr, 64'h8000_0004);

    // Stall held four cycles in HOLD
    stall = 1'b1;
    do_fetch(64'h8000_0004, 32'h00a0_0113, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", 64'(ifu_valid), 64'h1);
      check("stall_ins", 64'(ifu_ins), 64'h00a0_0113);
      check("stall_pc", ifu_pc, 64'h8000_0004);
      check("stall_req", 64'(imem_req), 64'h0);
    end
    stall = 1'b0;
    tick();
    check("rel_valid", 64'(ifu_valid), 64'h0);
    check("rel_addr", imem_addr, 64'h8000_0008);

    // Redirect in WAIT, stale response three cycles later
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h8000_0102;
    tick();
    redirect = 1'b0;
    check("rw_valid", 64'(ifu_valid), 64'h0);
    check("rw_req", 64'(imem_req), 64'h0);
    tick(); tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    tick();
    imem_rvalid = 1'b0;
    check("rw_dropped", 64'(ifu_valid), 64'h0);
    check("rw_req2", 64'(imem_req), 64'h1);
    check("rw_addr", imem_addr, 64'h8000_0100);
    do_fetch(64'h8000_0100, 32'h0010_0093, 1);
    tick();
    check("rw_next", imem_addr, 64'h8000_0104);

    // Redirect in the same cycle as grant
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    imem_gnt = 1'b0; redirect = 1'b0;
    check("rg_req", 64'(imem_req), 64'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hbad0_0001;
    tick();
    imem_rvalid = 1'b0;
    check("rg_valid", 64'(ifu_valid), 64'h0);
    check("rg_addr", imem_addr, 64'h8000_0200);

    // Redirect together with the response
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h8000_0300;
    imem_rvalid = 1'b1; imem_rdata = 32'hbad0_0002;
    tick();
    redirect = 1'b0; imem_rvalid = 1'b0;
    check("rv_valid", 64'(ifu_valid), 64'h0);
    check("rv_req", 64'(imem_req), 64'h1);
    check("rv_addr", imem_addr, 64'h8000_0300);

    // Redirect in HOLD while stalled
    stall = 1'b1;
    do_fetch(64'h8000_0300, 32'h0030_0193, 1);
    tick();
    redirect = 1'b1; redirect_pc = 64'h8000_0400;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check("rh_valid", 64'(ifu_valid), 64'h0);
    check("rh_ins", 64'(ifu_ins), c_nop);
    check("rh_pc", ifu_pc, 64'h0);
    check("rh_addr", imem_addr, 64'h8000_0400);

    // Reset in WAIT, late response ignored
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("wr_req_in_rst", 64'(imem_req), 64'h0);
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hbad0_0003;
    #1;
    check("wr_addr", imem_addr, 64'h8000_0000);
    tick();
    imem_rvalid = 1'b0;
    check("wr_late", 64'(ifu_valid), 64'h0);
    check("wr_req", 64'(imem_req), 64'h1);
    do_fetch(64'h8000_0000, 32'h0040_0213, 3);
    tick();

    // Redirect in REQ with unaligned target, then PC wrap
    redirect = 1'b1; redirect_pc = 64'hffff_ffff_ffff_fffe;
    tick();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 64'hffff_ffff_ffff_fffc);
    do_fetch(64'hffff_ffff_ffff_fffc, 32'h0050_0293, 1);
    tick();
    check("wrap_next", imem_addr, 64'h0);

    tick();
    check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22050078_ifu_fetch.md
# ysyx_22050078_ifu_fetch

Instruction fetch unit for the five-stage core: owns the architectural fetch PC, issues one instruction-memory request at a time, and presents each fetched instruction with its PC to the IF/ID pipeline register. Downstream the instruction is registered with write enable = !i_stall and bubble = !o_ifu_valid. Branch/jump redirects from EXU flush any in-flight or held fetch.

## Interface
- CPU_WIDTH, 64, PC/address width
- INS_WIDTH, 32, instruction width
- RESET_PC, 64'h8000_0000, first fetch address after reset
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_stall  in  1  downstream (hazard unit) cannot accept an instruction this cycle
- i_redirect  in  1  EXU control-flow redirect, single-cycle pulse
- i_redirect_pc  in  CPU_WIDTH  redirect target; bits [1:0] ignored (treated as 0)
- o_imem_req  out  1  request valid
- o_imem_addr  out  CPU_WIDTH  request address (current fetch PC, [1:0]=0)
- i_imem_gnt  in  1  request accepted this cycle (meaningful only while o_imem_req=1)
- i_imem_rvalid  in  1  response valid, exactly one per granted request, ≥1 cycle after grant
- i_imem_rdata  in  INS_WIDTH  response instruction
- o_ifu_valid  out  1  o_ifu_ins/o_ifu_pc hold a live instruction
- o_ifu_ins  out  INS_WIDTH  fetched instruction (32'h13 when not valid)
- o_ifu_pc  out  CPU_WIDTH  PC of o_ifu_ins (0 when not valid)

## Operation
- Registers: pc, req_pc, state, drop flag, output regs (valid/ins/pc). All outputs except o_imem_req/o_imem_addr are registered.
- States: REQ, WAIT, HOLD. One outstanding request maximum.
- REQ: o_imem_req=1, o_imem_addr=pc. On i_imem_gnt: req_pc<=pc, ->WAIT. Else stay.
- WAIT: o_imem_req=0. On i_imem_rvalid with drop=0: o_ifu_ins<=rdata, o_ifu_pc<=req_pc, o_ifu_valid<=1, pc<=req_pc+4, ->HOLD. With drop=1: discard data, drop<=0, ->REQ.
- HOLD: o_imem_req=0. If !i_stall (instruction consumed this cycle): o_ifu_valid<=0, ins<=32'h13, pc out<=0, ->REQ. Else hold all outputs.
- i_stall only affects HOLD; fetch proceeds in REQ/WAIT regardless.
- Redirect (priority over stall and normal flow), any state: pc<={i_redirect_pc[CPU_WIDTH-1:2],2'b00}; o_ifu_valid<=0, ins<=32'h13, pc out<=0.
  - REQ without gnt: stay REQ; next-cycle address is target.
  - REQ with gnt same cycle: ->WAIT, drop<=1 (old-path request in flight).
  - WAIT without rvalid: drop<=1, stay WAIT.
  - WAIT with rvalid same cycle: discard data, drop<=0, ->REQ.
  - HOLD: held instruction flushed, ->REQ.
- pc+4 wraps modulo 2^CPU_WIDTH; no overflow flag.
- i_imem_rvalid outside WAIT is ignored.

## Timing
- During i_rst=1: o_imem_req forced 0. Next edge sets state=REQ, pc=RESET_PC, drop=0, o_ifu_valid=0, o_ifu_ins=32'h13, o_ifu_pc=0, req_pc=0.
- First request asserted in first cycle after reset deasserts.
- Best case: gnt at cycle t, rvalid at t+1, o_ifu_valid=1 at t+2; consumed at t+2 -> o_imem_req=1 at t+3 with addr+4. Peak throughput one instruction per 3 cycles.
- Redirect at cycle t: o_ifu_valid=0 from t+1; first request to target no later than t+1 (REQ) or the cycle after the stale response returns (WAIT).
- Reset mid-operation overrides everything; any in-flight response after reset is ignored unless state is WAIT (impossible after reset, so dropped).

## Test plan
- Reset then gnt/rvalid immediate, rdata=32'h0000_0093, no stall -> o_imem_addr=0x8000_0000, o_ifu_valid=1 with o_ifu_pc=0x8000_0000, next addr 0x8000_0004.
- Stall held 4 cycles in HOLD -> outputs stable, o_imem_req=0 throughout; release -> valid drops, request to pc+4 next cycle.
- Redirect to 0x8000_0102 while in WAIT, rvalid 3 cycles later -> response discarded, o_ifu_valid stays 0, next request addr 0x8000_0100.
- Redirect same cycle as gnt in REQ -> stale response dropped, then request to target; redirect+rvalid same cycle -> data dropped, REQ next.
- Redirect in HOLD with i_stall=1 -> o_ifu_valid=0, ins=32'h13 next cycle, request to target.
- Synchronous reset asserted in WAIT -> o_imem_req=0 during reset, afterwards request to 0x8000_0000, late rvalid ignored.
